// File: rtl/register_file_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry, the zero-register
// address and port-slice helpers reused by decode and the hazard unit.
package register_file_mp_pkg;

    localparam int unsigned DefRegWidth  = 34;
    localparam int unsigned DefAddrWidth = 5;
    localparam int unsigned DefNumRd     = 2;
    localparam int unsigned DefNumWr     = 2;
    localparam bit          DefZeroReg   = 1'b1;
    localparam bit          DefBypass    = 1'b1;

    localparam int unsigned ZeroAddr = 0;

    function automatic int unsigned n_regs(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Low bit of port k inside a packed bus of w-bit fields.
    function automatic int unsigned port_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears (set wins on collision),
// registered busy count and combinational per-read-port busy flags.
module rf_scoreboard
    import register_file_mp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned NUM_RD     = DefNumRd,
    parameter int unsigned NUM_WR     = DefNumWr,
    parameter bit          ZERO_REG   = DefZeroReg,
    parameter bit          BYPASS     = DefBypass
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_WR-1:0]            i_wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                         i_sb_set,
    input  logic [ADDR_WIDTH-1:0]        i_sb_addr,
    output logic [NUM_RD-1:0]            o_rd_busy,
    output logic [ADDR_WIDTH:0]          o_busy_count
);

    localparam int unsigned NRegs = n_regs(ADDR_WIDTH);

    logic [NRegs-1:0]    busy_q, busy_d;
    logic [NRegs-1:0]    set_vec, clr_vec;
    logic [ADDR_WIDTH:0] count_q, count_d;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (i_sb_set) begin
            set_vec[i_sb_addr] = 1'b1;
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (i_wr_en[k]) begin
                clr_vec[i_wr_addr[port_lo(k, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b1;
            end
        end
        // A new producer issued in the same cycle as the old one retires keeps the reg busy.
        busy_d = (busy_q & ~clr_vec) | set_vec;
        if (ZERO_REG) begin
            busy_d[ZeroAddr] = 1'b0;
        end
        count_d = '0;
        for (int i = 0; i < NRegs; i++) begin
            count_d = count_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign o_busy_count = count_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_busy
        logic [ADDR_WIDTH-1:0] ra;
        logic                  busy;

        assign ra = i_rd_addr[port_lo(p, ADDR_WIDTH) +: ADDR_WIDTH];

        always_comb begin
            busy = busy_q[ra];
            if (BYPASS && clr_vec[ra] && !set_vec[ra]) begin
                busy = 1'b0;
            end
            if (ZERO_REG && ra == '0) begin
                busy = 1'b0;
            end
            if (!rst_n) begin
                busy = 1'b0;
            end
        end

        assign o_rd_busy[p] = busy;
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_WR write ports (highest index wins), NUM_RD combinational read
// ports with optional write bypass and hard-wired zero register, plus busy scoreboard.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int unsigned REG_WIDTH  = DefRegWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned NUM_RD     = DefNumRd,
    parameter int unsigned NUM_WR     = DefNumWr,
    parameter bit          ZERO_REG   = DefZeroReg,
    parameter bit          BYPASS     = DefBypass
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_WR-1:0]            i_wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [NUM_WR*REG_WIDTH-1:0]  i_wr_data,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_RD*REG_WIDTH-1:0]  o_rd_data,
    output logic [NUM_RD-1:0]            o_rd_busy,
    input  logic                         i_sb_set,
    input  logic [ADDR_WIDTH-1:0]        i_sb_addr,
    output logic [ADDR_WIDTH:0]          o_busy_count
);

    localparam int unsigned NRegs = n_regs(ADDR_WIDTH);

    logic [REG_WIDTH-1:0] regs_q [NRegs];
    logic [REG_WIDTH-1:0] regs_d [NRegs];

    // Later ports overwrite earlier ones, so the highest index wins on an address clash.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (i_wr_en[k]) begin
                if (!(ZERO_REG && i_wr_addr[port_lo(k, ADDR_WIDTH) +: ADDR_WIDTH] == '0)) begin
                    regs_d[i_wr_addr[port_lo(k, ADDR_WIDTH) +: ADDR_WIDTH]] =
                        i_wr_data[port_lo(k, REG_WIDTH) +: REG_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [REG_WIDTH-1:0]  rdata;

        assign ra = i_rd_addr[port_lo(p, ADDR_WIDTH) +: ADDR_WIDTH];

        always_comb begin
            rdata = regs_q[ra];
            if (BYPASS) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (i_wr_en[k] && i_wr_addr[port_lo(k, ADDR_WIDTH) +: ADDR_WIDTH] == ra) begin
                        rdata = i_wr_data[port_lo(k, REG_WIDTH) +: REG_WIDTH];
                    end
                end
            end
            if (ZERO_REG && ra == '0) begin
                rdata = '0;
            end
            // Bypass must not leak write data while reset is held.
            if (!rst_n) begin
                rdata = '0;
            end
        end

        assign o_rd_data[port_lo(p, REG_WIDTH) +: REG_WIDTH] = rdata;
    end

    rf_scoreboard #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_RD    (NUM_RD),
        .NUM_WR    (NUM_WR),
        .ZERO_REG  (ZERO_REG),
        .BYPASS    (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_rd_addr   (i_rd_addr),
        .i_sb_set    (i_sb_set),
        .i_sb_addr   (i_sb_addr),
        .o_rd_busy   (o_rd_busy),
        .o_busy_count(o_busy_count)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: default instance plus a BYPASS=0/ZERO_REG=0 instance
// sharing the same stimulus.
module tb_register_file_mp;

    localparam int unsigned RW = 34;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*RW-1:0] wr_data;
    logic [2*AW-1:0] rd_addr;
    logic [2*RW-1:0] rd_data, rd_data_np;
    logic [1:0]    rd_busy, rd_busy_np;
    logic          sb_set;
    logic [AW-1:0] sb_addr;
    logic [AW:0]   busy_count, busy_count_np;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    register_file_mp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_rd_busy   (rd_busy),
        .i_sb_set    (sb_set),
        .i_sb_addr   (sb_addr),
        .o_busy_count(busy_count)
    );

    register_file_mp #(
        .ZERO_REG(1'b0),
        .BYPASS  (1'b0)
    ) dut_np (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data_np),
        .o_rd_busy   (rd_busy_np),
        .i_sb_set    (sb_set),
        .i_sb_addr   (sb_addr),
        .o_busy_count(busy_count_np)
    );

    task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle();
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        sb_set  = 1'b0;
        sb_addr = '0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [RW-1:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*RW +: RW] = d;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic sb(input logic [AW-1:0] a);
        sb_set  = 1'b1;
        sb_addr = a;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst_n   = 1'b0;
        rd_addr = '0;
        idle();

        // 1: reset state, then asynchronous reset mid-operation
        #3;
        check_eq("rst_count", 34'(busy_count), 34'd0);
        check_eq("rst_busy", 34'(rd_busy), 34'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wr(0, 5'd10, 34'h2_0000_0001);
        sb(5'd11);
        step();
        rd(0, 5'd10);
        rd(1, 5'd11);
        #1;
        check_eq("pre_rst_data", rd_data[RW-1:0], 34'h2_0000_0001);
        check_eq("pre_rst_busy", 34'(rd_busy[1]), 34'd1);
        check_eq("pre_rst_count", 34'(busy_count), 34'd1);
        #1;
        rst_n = 1'b0;
        wr(0, 5'd10, 34'h1_1111_1111);
        #1;
        check_eq("async_rst_data", rd_data[RW-1:0], 34'd0);
        check_eq("async_rst_busy", 34'(rd_busy), 34'd0);
        check_eq("async_rst_count", 34'(busy_count), 34'd0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // 2: basic write/read and dropped r0 write
        wr(0, 5'd5, 34'h1_2345_6789);
        wr(1, 5'd0, 34'h3FF);
        step();
        rd(0, 5'd5);
        rd(1, 5'd0);
        #1;
        check_eq("rd_r5", rd_data[RW-1:0], 34'h1_2345_6789);
        check_eq("rd_r0_zero", rd_data[2*RW-1:RW], 34'd0);
        check_eq("np_rd_r0", rd_data_np[2*RW-1:RW], 34'h3FF);

        // 3: same-address write conflict and bypass
        wr(0, 5'd7, 34'hAA);
        wr(1, 5'd7, 34'h55);
        rd(0, 5'd7);
        #1;
        check_eq("bypass_r7", rd_data[RW-1:0], 34'h55);
        check_eq("np_nobypass_r7", rd_data_np[RW-1:0], 34'd0);
        step();
        #1;
        check_eq("stored_r7", rd_data[RW-1:0], 34'h55);

        // 4: scoreboard set/clear
        sb(5'd3);
        step();
        rd(0, 5'd3);
        #1;
        check_eq("busy_r3", 34'(rd_busy[0]), 34'd1);
        check_eq("count_1", 34'(busy_count), 34'd1);
        sb(5'd4);
        step();
        #1;
        check_eq("count_2", 34'(busy_count), 34'd2);
        wr(0, 5'd3, 34'h33);
        #1;
        check_eq("busy_r3_wb_mask", 34'(rd_busy[0]), 34'd0);
        step();
        #1;
        check_eq("busy_r3_cleared", 34'(rd_busy[0]), 34'd0);
        check_eq("count_after_wb", 34'(busy_count), 34'd1);

        // 5: set and write the same busy register in one cycle
        sb(5'd9);
        step();
        #1;
        check_eq("count_r9", 34'(busy_count), 34'd2);
        sb(5'd9);
        wr(1, 5'd9, 34'h99);
        rd(1, 5'd9);
        #1;
        check_eq("busy_r9_setwins", 34'(rd_busy[1]), 34'd1);
        step();
        #1;
        check_eq("busy_r9_after", 34'(rd_busy[1]), 34'd1);
        check_eq("data_r9", rd_data[2*RW-1:RW], 34'h99);
        check_eq("count_same", 34'(busy_count), 34'd2);

        // 6: r0 write and scoreboard set: ignored with ZERO_REG, tracked without
        wr(0, 5'd0, 34'h3FF);
        sb(5'd0);
        step();
        rd(0, 5'd0);
        #1;
        check_eq("r0_zero", rd_data[RW-1:0], 34'd0);
        check_eq("r0_busy_zero", 34'(rd_busy[0]), 34'd0);
        check_eq("count_r0_ignored", 34'(busy_count), 34'd2);
        check_eq("np_r0_data", rd_data_np[RW-1:0], 34'h3FF);
        check_eq("np_r0_busy", 34'(rd_busy_np[0]), 34'd1);
        check_eq("np_count", 34'(busy_count_np), 34'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
